// File: rtl/row_argmax.sv
// Row-scoring sequencer: drives the multiplier one row at a time and keeps the signed argmax.
// Latency is NUM_ROWS*(1+D)+1 cycles from start to done; stalls wait on done_row, watchdog aborts.
module row_argmax #(
  parameter int NUM_ROWS = 10,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        done_row,
  input  logic [31:0] row_result,
  input  logic        overflow,
  output logic [3:0]  row_select,
  output logic        begin_mult,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit,
  output logic [31:0] max_value,
  output logic        sat_seen,
  output logic        error
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [31:0]   best_q, best_d;
  logic [3:0]    digit_q, digit_d;
  logic          sat_q, sat_d;
  logic          err_q, err_d;
  logic [31:0]   score;

  // Overflow flips the sign bit, so a set MSB means the true sum was positive.
  always_comb begin
    score = row_result;
    if (overflow) begin
      score = row_result[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wdog_d  = wdog_q;
    best_d  = best_q;
    digit_d = digit_q;
    sat_d   = sat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = 4'd0;
          best_d  = 32'd0;
          digit_d = 4'd0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // done_row takes priority over a watchdog expiry in the same cycle.
        if (done_row) begin
          if ((row_q == 4'd0) || ($signed(score) > $signed(best_q))) begin
            best_d  = score;
            digit_d = row_q;
          end
          if (overflow) begin
            sat_d = 1'b1;
          end
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 4'd0;
      wdog_q  <= '0;
      best_q  <= 32'd0;
      digit_q <= 4'd0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wdog_q  <= wdog_d;
      best_q  <= best_d;
      digit_q <= digit_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign row_select = row_q;
  assign begin_mult = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign digit      = digit_q;
  assign max_value  = best_q;
  assign sat_seen   = sat_q;
  assign error      = err_q;

endmodule
